// File: rtl/vga_dac_seq_fml.sv
// CPU-side sequencer for the VGA DAC colour registers at 3C6h-3C9h.
// Handles single-beat I/O accesses, the DAC index/cycle counters and the PEL mask.
module vga_dac_seq_fml #(
    parameter logic [7:0] PEL_MASK_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_stb,
    input  logic       io_we,
    input  logic [1:0] io_addr,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       io_ack,
    output logic [7:0] pel_mask,
    output logic       dac_we,
    output logic [1:0] dac_write_data_cycle,
    output logic [7:0] dac_write_data_register,
    output logic [3:0] dac_write_data,
    output logic [1:0] dac_read_data_cycle,
    output logic [7:0] dac_read_data_register,
    input  logic [3:0] dac_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_RIDX = 2'd1;
    localparam logic [1:0] A_WIDX = 2'd2;
    localparam logic [1:0] A_DATA = 2'd3;

    state_t      state_q, state_d;
    logic [7:0]  io_rdata_q, io_rdata_d;
    logic [7:0]  pel_mask_q, pel_mask_d;
    logic        dac_we_q, dac_we_d;
    logic [3:0]  wdat_q, wdat_d;
    logic [1:0]  wcyc_q, wcyc_d;
    logic [7:0]  wreg_q, wreg_d;
    logic [1:0]  rcyc_q, rcyc_d;
    logic [7:0]  rreg_q, rreg_d;
    logic [1:0]  dac_state_q, dac_state_d;
    logic        cmd_we_q, cmd_we_d;
    logic        cmd_data_q, cmd_data_d;

    // Step an {index, component} pair through R, G, B and on to the next index.
    function automatic logic [9:0] advance(input logic [7:0] idx, input logic [1:0] cyc);
        logic [9:0] res;
        if (cyc == 2'd2) begin
            res = {idx + 8'd1, 2'd0};
        end else begin
            res = {idx, cyc + 2'd1};
        end
        return res;
    endfunction

    // Next-state and datapath decode for the access sequencer.
    always_comb begin
        state_d     = state_q;
        io_rdata_d  = io_rdata_q;
        pel_mask_d  = pel_mask_q;
        dac_we_d    = dac_we_q;
        wdat_d      = wdat_q;
        wcyc_d      = wcyc_q;
        wreg_d      = wreg_q;
        rcyc_d      = rcyc_q;
        rreg_d      = rreg_q;
        dac_state_d = dac_state_q;
        cmd_we_d    = cmd_we_q;
        cmd_data_d  = cmd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (io_stb) begin
                    cmd_we_d   = io_we;
                    cmd_data_d = (io_addr == A_DATA);
                    if (io_we) begin
                        state_d = ST_ACK;
                        case (io_addr)
                            A_MASK: pel_mask_d = io_wdata;
                            A_RIDX: begin
                                rreg_d      = io_wdata;
                                rcyc_d      = 2'd0;
                                dac_state_d = 2'b11;
                            end
                            A_WIDX: begin
                                wreg_d      = io_wdata;
                                wcyc_d      = 2'd0;
                                dac_state_d = 2'b00;
                            end
                            A_DATA: begin
                                dac_we_d = 1'b1;
                                wdat_d   = io_wdata[5:2];
                            end
                            default: state_d = ST_ACK;
                        endcase
                    end else if (io_addr == A_DATA) begin
                        // Read address is already on the port; wait one clk for the data.
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_ACK;
                        case (io_addr)
                            A_MASK:  io_rdata_d = pel_mask_q;
                            A_RIDX:  io_rdata_d = {6'b000000, dac_state_q};
                            A_WIDX:  io_rdata_d = wreg_q;
                            default: io_rdata_d = io_rdata_q;
                        endcase
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                io_rdata_d = {2'b00, dac_read_data, 2'b00};
                state_d    = ST_ACK;
            end
            ST_ACK: begin
                dac_we_d = 1'b0;
                state_d  = ST_IDLE;
                if (cmd_data_q && cmd_we_q) begin
                    {wreg_d, wcyc_d} = advance(wreg_q, wcyc_q);
                end else if (cmd_data_q) begin
                    {rreg_d, rcyc_d} = advance(rreg_q, rcyc_q);
                end else begin
                    cmd_data_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                dac_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            io_rdata_q  <= 8'h00;
            pel_mask_q  <= PEL_MASK_RST;
            dac_we_q    <= 1'b0;
            wdat_q      <= 4'h0;
            wcyc_q      <= 2'd0;
            wreg_q      <= 8'h00;
            rcyc_q      <= 2'd0;
            rreg_q      <= 8'h00;
            dac_state_q <= 2'b00;
            cmd_we_q    <= 1'b0;
            cmd_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            io_rdata_q  <= io_rdata_d;
            pel_mask_q  <= pel_mask_d;
            dac_we_q    <= dac_we_d;
            wdat_q      <= wdat_d;
            wcyc_q      <= wcyc_d;
            wreg_q      <= wreg_d;
            rcyc_q      <= rcyc_d;
            rreg_q      <= rreg_d;
            dac_state_q <= dac_state_d;
            cmd_we_q    <= cmd_we_d;
            cmd_data_q  <= cmd_data_d;
        end
    end

    assign io_ack                  = (state_q == ST_ACK);
    assign io_rdata                = io_rdata_q;
    assign pel_mask                = pel_mask_q;
    assign dac_we                  = dac_we_q;
    assign dac_write_data          = wdat_q;
    assign dac_write_data_cycle    = wcyc_q;
    assign dac_write_data_register = wreg_q;
    assign dac_read_data_cycle     = rcyc_q;
    assign dac_read_data_register  = rreg_q;

endmodule

// File: tb/tb_vga_dac_seq_fml.sv
// Bench for vga_dac_seq_fml: directed vector table, hand-written corner sequences,
// then randomized traffic against a palette-level reference model.
module tb_vga_dac_seq_fml;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_stb, io_we;
    logic [1:0] io_addr;
    logic [7:0] io_wdata, io_rdata;
    logic       io_ack;
    logic [7:0] pel_mask;
    logic       dac_we;
    logic [1:0] dac_write_data_cycle, dac_read_data_cycle;
    logic [7:0] dac_write_data_register, dac_read_data_register;
    logic [3:0] dac_write_data, dac_read_data;

    int n_cmp = 0;
    int n_fail = 0;
    int we_pulses = 0;

    always #5 clk = ~clk;

    vga_dac_seq_fml #(.PEL_MASK_RST(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .io_stb(io_stb), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack), .pel_mask(pel_mask),
        .dac_we(dac_we),
        .dac_write_data_cycle(dac_write_data_cycle),
        .dac_write_data_register(dac_write_data_register),
        .dac_write_data(dac_write_data),
        .dac_read_data_cycle(dac_read_data_cycle),
        .dac_read_data_register(dac_read_data_register),
        .dac_read_data(dac_read_data)
    );

    // Stand-in DAC register file: written by the strobe, read with one clk latency.
    logic [3:0] pal_hw [0:255][0:2];
    logic       rd_const_en;
    logic [3:0] rd_const;
    always @(posedge clk) begin
        if (dac_we) pal_hw[dac_write_data_register][dac_write_data_cycle] <= dac_write_data;
        dac_read_data <= rd_const_en ? rd_const
                                     : pal_hw[dac_read_data_register][dac_read_data_cycle];
    end

    always @(posedge clk) if (dac_we) we_pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete I/O access; snap = {dac_we, wr cycle, wr register, wr data} seen at ack.
    task automatic do_io(input logic we, input logic [1:0] addr, input logic [7:0] wd,
                         output logic [7:0] rd, output int lat,
                         output logic [14:0] snap, output int pulses);
        int p0;
        bit got;
        p0 = we_pulses;
        got = 1'b0;
        lat = 0;
        rd = 8'h00;
        snap = 15'h0;
        io_we = we; io_addr = addr; io_wdata = wd; io_stb = 1'b1;
        for (int i = 1; i <= 8 && !got; i++) begin
            @(posedge clk); #1;
            if (io_ack) begin
                got = 1'b1;
                lat = i;
                rd = io_rdata;
                snap = {dac_we, dac_write_data_cycle, dac_write_data_register, dac_write_data};
            end
        end
        io_stb = 1'b0;
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL ack_timeout: got no ack, expected ack within 8 clk (addr=%0d we=%0d)", addr, we);
        end
        @(posedge clk); #1;
        pulses = we_pulses - p0;
    endtask

    task automatic do_reset();
        io_stb = 1'b0; io_we = 1'b0; io_addr = 2'd0; io_wdata = 8'h00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [7:0]  wd;
        logic [7:0]  e_rd;
        int          e_lat;
        logic [14:0] e_snap;
        logic [7:0]  e_wreg;
        logic [1:0]  e_wcyc;
        logic [7:0]  e_rreg;
        logic [1:0]  e_rcyc;
        logic [7:0]  e_pel;
    } vec_t;
    vec_t tbl [14];

    // Reference model: palette as a flat array of 768 components addressed by pointers.
    int         m_pel, m_dst, m_wp, m_rp;
    logic [7:0] m_last;
    logic [3:0] m_pal [768];

    task automatic model_reset();
        m_pel = 255; m_dst = 0; m_wp = 0; m_rp = 0; m_last = 8'h00;
    endtask

    task automatic model_txn(input logic we, input logic [1:0] addr, input logic [7:0] wd);
        logic [7:0]  rd;
        int          lat, pulses, e_lat;
        logic [14:0] snap, e_snap;
        e_lat = (!we && addr == 2'd3) ? 2 : 1;
        e_snap = 15'h0;
        if (we) begin
            case (addr)
                2'd0: m_pel = int'(wd);
                2'd1: begin m_rp = int'(wd) * 3; m_dst = 3; end
                2'd2: begin m_wp = int'(wd) * 3; m_dst = 0; end
                default: begin
                    e_snap = {1'b1, 2'(m_wp % 3), 8'(m_wp / 3), wd[5:2]};
                    m_pal[m_wp] = wd[5:2];
                    m_wp = (m_wp + 1) % 768;
                end
            endcase
        end else begin
            case (addr)
                2'd0: m_last = 8'(m_pel);
                2'd1: m_last = 8'(m_dst);
                2'd2: m_last = 8'(m_wp / 3);
                default: begin
                    m_last = {2'b00, m_pal[m_rp], 2'b00};
                    m_rp = (m_rp + 1) % 768;
                end
            endcase
        end
        do_io(we, addr, wd, rd, lat, snap, pulses);
        check("rnd_rdata", rd, m_last);
        check("rnd_latency", lat, e_lat);
        check("rnd_we_pulses", pulses, e_snap[14]);
        if (e_snap[14]) check("rnd_dac_write", snap, e_snap);
        check("rnd_wptr", int'(dac_write_data_register) * 3 + int'(dac_write_data_cycle), m_wp);
        check("rnd_rptr", int'(dac_read_data_register) * 3 + int'(dac_read_data_cycle), m_rp);
        check("rnd_pel", pel_mask, m_pel);
    endtask

    initial begin
        logic [7:0]  rd;
        int          lat, pulses, acks;
        logic [14:0] snap;

        tbl[0]  = '{1'b1, 2'd2, 8'h10, 8'h00, 1, 15'h0, 8'h10, 2'd0, 8'h00, 2'd0, 8'hFF};
        tbl[1]  = '{1'b1, 2'd3, 8'h3F, 8'h00, 1, {1'b1, 2'd0, 8'h10, 4'hF}, 8'h10, 2'd1, 8'h00, 2'd0, 8'hFF};
        tbl[2]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1, {1'b1, 2'd1, 8'h10, 4'h0}, 8'h10, 2'd2, 8'h00, 2'd0, 8'hFF};
        tbl[3]  = '{1'b1, 2'd3, 8'h20, 8'h00, 1, {1'b1, 2'd2, 8'h10, 4'h8}, 8'h11, 2'd0, 8'h00, 2'd0, 8'hFF};
        tbl[4]  = '{1'b1, 2'd1, 8'hFF, 8'h00, 1, 15'h0, 8'h11, 2'd0, 8'hFF, 2'd0, 8'hFF};
        tbl[5]  = '{1'b0, 2'd3, 8'h00, 8'h28, 2, 15'h0, 8'h11, 2'd0, 8'hFF, 2'd1, 8'hFF};
        tbl[6]  = '{1'b0, 2'd3, 8'h00, 8'h28, 2, 15'h0, 8'h11, 2'd0, 8'hFF, 2'd2, 8'hFF};
        tbl[7]  = '{1'b0, 2'd3, 8'h00, 8'h28, 2, 15'h0, 8'h11, 2'd0, 8'h00, 2'd0, 8'hFF};
        tbl[8]  = '{1'b0, 2'd1, 8'h00, 8'h03, 1, 15'h0, 8'h11, 2'd0, 8'h00, 2'd0, 8'hFF};
        tbl[9]  = '{1'b1, 2'd2, 8'h05, 8'h03, 1, 15'h0, 8'h05, 2'd0, 8'h00, 2'd0, 8'hFF};
        tbl[10] = '{1'b0, 2'd1, 8'h00, 8'h00, 1, 15'h0, 8'h05, 2'd0, 8'h00, 2'd0, 8'hFF};
        tbl[11] = '{1'b0, 2'd2, 8'h00, 8'h05, 1, 15'h0, 8'h05, 2'd0, 8'h00, 2'd0, 8'hFF};
        tbl[12] = '{1'b1, 2'd0, 8'h0F, 8'h05, 1, 15'h0, 8'h05, 2'd0, 8'h00, 2'd0, 8'h0F};
        tbl[13] = '{1'b0, 2'd0, 8'h00, 8'h0F, 1, 15'h0, 8'h05, 2'd0, 8'h00, 2'd0, 8'h0F};

        rd_const_en = 1'b1;
        rd_const = 4'hA;
        do_reset();

        check("rst_pel", pel_mask, 8'hFF);
        check("rst_dac_we", dac_we, 1'b0);
        check("rst_ack", io_ack, 1'b0);
        check("rst_rdata", io_rdata, 8'h00);
        check("rst_wptr", {dac_write_data_register, dac_write_data_cycle}, 10'h0);
        check("rst_rptr", {dac_read_data_register, dac_read_data_cycle}, 10'h0);

        for (int i = 0; i < 14; i++) begin
            do_io(tbl[i].we, tbl[i].addr, tbl[i].wd, rd, lat, snap, pulses);
            check($sformatf("v%0d_rdata", i), rd, tbl[i].e_rd);
            check($sformatf("v%0d_latency", i), lat, tbl[i].e_lat);
            check($sformatf("v%0d_dac_we", i), snap[14], tbl[i].e_snap[14]);
            check($sformatf("v%0d_we_pulses", i), pulses, tbl[i].e_snap[14]);
            if (tbl[i].e_snap[14]) check($sformatf("v%0d_dac_write", i), snap, tbl[i].e_snap);
            check($sformatf("v%0d_wreg", i), dac_write_data_register, tbl[i].e_wreg);
            check($sformatf("v%0d_wcyc", i), dac_write_data_cycle, tbl[i].e_wcyc);
            check($sformatf("v%0d_rreg", i), dac_read_data_register, tbl[i].e_rreg);
            check($sformatf("v%0d_rcyc", i), dac_read_data_cycle, tbl[i].e_rcyc);
            check($sformatf("v%0d_pel", i), pel_mask, tbl[i].e_pel);
        end

        // Strobe held high: a new access starts in the IDLE cycle after each ack.
        io_we = 1'b1; io_addr = 2'd0; io_wdata = 8'h5A; io_stb = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (io_ack) acks++;
        end
        io_stb = 1'b0;
        @(posedge clk); #1;
        check("held_stb_acks", acks, 3);
        check("held_stb_pel", pel_mask, 8'h5A);

        // Strobe dropped during RD: the read still completes.
        rd_const = 4'h6;
        io_we = 1'b0; io_addr = 2'd3; io_stb = 1'b1;
        @(posedge clk); #1;
        io_stb = 1'b0;
        check("drop_stb_no_early_ack", io_ack, 1'b0);
        @(posedge clk); #1;
        check("drop_stb_ack", io_ack, 1'b1);
        check("drop_stb_rdata", io_rdata, 8'h18);
        @(posedge clk); #1;
        check("drop_stb_rcyc", dac_read_data_cycle, 2'd1);

        // Reset while a 3C9 read sits in RD: no ack, counters back to reset.
        io_we = 1'b0; io_addr = 2'd3; io_stb = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        io_stb = 1'b0;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (io_ack) acks++;
        end
        check("rst_rd_acks", acks, 0);
        check("rst_rd_rcyc", dac_read_data_cycle, 2'd0);
        check("rst_rd_rdata", io_rdata, 8'h00);
        check("rst_rd_pel", pel_mask, 8'hFF);

        // Randomized traffic: fill the palette through the DUT, then mixed accesses.
        rd_const_en = 1'b0;
        do_reset();
        model_reset();
        model_txn(1'b1, 2'd2, 8'h00);
        for (int i = 0; i < 768; i++) model_txn(1'b1, 2'd3, 8'($urandom));
        for (int i = 0; i < 400; i++) begin
            logic [1:0] a;
            logic       w;
            a = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            model_txn(w, a, 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
